// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and grant encoding for the register-file write arbiter.
// Imported by reg_write_slot and reg_write_arbiter.
package reg_write_arbiter_pkg;

    localparam logic [4:0]  REG_ADDR_ZERO = 5'b00000;
    localparam logic [31:0] WORD_ZERO     = 32'h0000_0000;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

endpackage

// File: rtl/reg_write_slot.sv
// One-entry holding register for a writeback requester.
// Writes to register 0 are accepted but never become valid.
module reg_write_slot
    import reg_write_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc,
    input  logic              clr,
    input  logic [ADDR_W-1:0] in_reg,
    input  logic [DATA_W-1:0] in_data,
    output logic              slot_v,
    output logic [ADDR_W-1:0] slot_reg,
    output logic [DATA_W-1:0] slot_data
);

    logic              v_q, v_d;
    logic [ADDR_W-1:0] reg_q, reg_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A same-edge accept wins over the clear so a lone requester streams.
    always_comb begin
        v_d    = v_q;
        reg_d  = reg_q;
        data_d = data_q;
        if (acc) begin
            reg_d  = in_reg;
            data_d = in_data;
            v_d    = (in_reg != ADDR_W'(REG_ADDR_ZERO));
        end else if (clr) begin
            v_d = 1'b0;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= 1'b0;
            reg_q  <= ADDR_W'(REG_ADDR_ZERO);
            data_q <= DATA_W'(WORD_ZERO);
        end else begin
            v_q    <= v_d;
            reg_q  <= reg_d;
            data_q <= data_d;
        end
    end

    assign slot_v    = v_q;
    assign slot_reg  = reg_q;
    assign slot_data = data_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A)
// and load (B) writeback. Optional forwarding ports under REGWR_FWD_EN.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              reg_write,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt
`ifdef REGWR_FWD_EN
    ,
    input  logic [ADDR_W-1:0] fwd_reg1,
    input  logic [ADDR_W-1:0] fwd_reg2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2
`endif
);

    logic              hold_a_v, hold_b_v;
    logic [ADDR_W-1:0] hold_a_reg, hold_b_reg;
    logic [DATA_W-1:0] hold_a_data, hold_b_data;
    logic              grant_a, grant_b;
    logic              acc_a, acc_b;

    grant_e            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              reg_write_q, reg_write_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    reg_write_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .acc       (acc_a),
        .clr       (grant_a),
        .in_reg    (a_reg),
        .in_data   (a_data),
        .slot_v    (hold_a_v),
        .slot_reg  (hold_a_reg),
        .slot_data (hold_a_data)
    );

    reg_write_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .acc       (acc_b),
        .clr       (grant_b),
        .in_reg    (b_reg),
        .in_data   (b_data),
        .slot_v    (hold_b_v),
        .slot_reg  (hold_b_reg),
        .slot_data (hold_b_data)
    );

    // Grant from slot state only; on a tie the side not granted last wins.
    always_comb begin
        grant_a = hold_a_v && (!hold_b_v || last_grant_q == GRANT_B);
        grant_b = hold_b_v && (!hold_a_v || last_grant_q == GRANT_A);
    end

    assign a_ready = !hold_a_v || grant_a;
    assign b_ready = !hold_b_v || grant_b;
    assign acc_a   = a_valid && a_ready;
    assign acc_b   = b_valid && b_ready;
    assign busy    = hold_a_v || hold_b_v;

    // Next output-stage contents, round-robin pointer and stall count.
    always_comb begin
        logic [1:0]     stall_inc;
        logic [CNT_W:0] stall_sum;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        reg_write_d  = grant_a || grant_b;
        last_grant_d = last_grant_q;
        if (grant_a) begin
            write_reg_d  = hold_a_reg;
            write_data_d = hold_a_data;
            last_grant_d = GRANT_A;
        end else if (grant_b) begin
            write_reg_d  = hold_b_reg;
            write_data_d = hold_b_data;
            last_grant_d = GRANT_B;
        end
        stall_inc = {1'b0, a_valid && !a_ready}
                  + {1'b0, b_valid && !b_ready};
        stall_sum = {1'b0, stall_cnt_q} + (CNT_W+1)'(stall_inc);
        if (stall_sum[CNT_W]) begin
            stall_cnt_d = '1;
        end else begin
            stall_cnt_d = stall_sum[CNT_W-1:0];
        end
    end

    // Output stage and arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_B;
            write_reg_q  <= ADDR_W'(REG_ADDR_ZERO);
            write_data_q <= DATA_W'(WORD_ZERO);
            reg_write_q  <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
    assign reg_write  = reg_write_q;
    assign stall_cnt  = stall_cnt_q;

`ifdef REGWR_FWD_EN
    // Newest copy first: waiting slot, then granted slot, then output stage.
    function automatic logic [DATA_W:0] fwd_lookup(
        input logic [ADDR_W-1:0] r
    );
        logic ng_a, ng_b;
        ng_a = hold_a_v && !grant_a;
        ng_b = hold_b_v && !grant_b;
        fwd_lookup = '0;
        if (r == ADDR_W'(REG_ADDR_ZERO)) begin
            fwd_lookup = '0;
        end else if (ng_a && hold_a_reg == r) begin
            fwd_lookup = {1'b1, hold_a_data};
        end else if (ng_b && hold_b_reg == r) begin
            fwd_lookup = {1'b1, hold_b_data};
        end else if (grant_a && hold_a_reg == r) begin
            fwd_lookup = {1'b1, hold_a_data};
        end else if (grant_b && hold_b_reg == r) begin
            fwd_lookup = {1'b1, hold_b_data};
        end else if (reg_write_q && write_reg_q == r) begin
            fwd_lookup = {1'b1, write_data_q};
        end
    endfunction

    // Two independent combinational forwarding lookups.
    always_comb begin
        {fwd_hit1, fwd_data1} = fwd_lookup(fwd_reg1);
        {fwd_hit2, fwd_data2} = fwd_lookup(fwd_reg2);
    end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter.
// Forwarding checks are compiled in when REGWR_FWD_EN is defined.
module tb_reg_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic        busy;
    logic [15:0] stall_cnt;
`ifdef REGWR_FWD_EN
    logic [4:0]  fwd_reg1, fwd_reg2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rf [0:31];

    reg_write_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_reg      (a_reg),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_reg      (b_reg),
        .b_data     (b_data),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .busy       (busy),
        .stall_cnt  (stall_cnt)
`ifdef REGWR_FWD_EN
        ,
        .fwd_reg1   (fwd_reg1),
        .fwd_reg2   (fwd_reg2),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model capturing the write port.
    always @(posedge clk) begin
        if (reg_write) rf[write_reg] <= write_data;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rst_n = 1'b0;
        a_valid = 1'b0; a_reg = 5'd0; a_data = 32'h0;
        b_valid = 1'b0; b_reg = 5'd0; b_data = 32'h0;
`ifdef REGWR_FWD_EN
        fwd_reg1 = 5'd0; fwd_reg2 = 5'd0;
`endif
        #12 rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_reg_write", reg_write, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_a_ready", a_ready, 1);

        // Reset mid-operation
        a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h77;
        tick();
        check("t1_busy_held", busy, 1);
        a_valid = 1'b0;
        tick();
        check("t1_issue", reg_write, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_rw", reg_write, 0);
        check("t1_async_wr", write_reg, 0);
        check("t1_async_wd", write_data, 0);
        check("t1_async_busy", busy, 0);
        #1 rst_n = 1'b1;
        tick();
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h33;
        b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h44;
        check("t1_a_ready", a_ready, 1);
        check("t1_b_ready", b_ready, 1);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("t1_tie_a_rdy", a_ready, 1);
        check("t1_tie_b_rdy", b_ready, 0);
        tick();
        check("t1_first_rw", reg_write, 1);
        check("t1_first_reg", write_reg, 3);
        check("t1_first_data", write_data, 32'h33);
        tick();
        check("t1_second_reg", write_reg, 4);
        check("t1_second_data", write_data, 32'h44);
        tick();
        check("t1_idle_rw", reg_write, 0);
        check("t1_hold_reg", write_reg, 4);
        check("t1_idle_busy", busy, 0);

        // Lone requester streams one write per cycle
        a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h0000_FFFF;
        check("t2_ready0", a_ready, 1);
        tick();
        check("t2_ready1", a_ready, 1);
        a_reg = 5'd2; a_data = 32'h1234_5678;
        tick();
        check("t2_rw0", reg_write, 1);
        check("t2_reg0", write_reg, 1);
        check("t2_ready2", a_ready, 1);
        a_valid = 1'b0;
        tick();
        check("t2_rw1", reg_write, 1);
        check("t2_reg1", write_reg, 2);
        tick();
        check("t2_rw_end", reg_write, 0);
        check("t2_rf1", rf[1], 32'h0000_FFFF);
        check("t2_rf2", rf[2], 32'h1234_5678);

        // Both held: alternating grants, one stall per cycle
        do_reset();
        a_valid = 1'b1; a_reg = 5'd3;  a_data = 32'hAAAA_0000;
        b_valid = 1'b1; b_reg = 5'd30; b_data = 32'hFFFF_0000;
        tick();
        check("t3_a_rdy", a_ready, 1);
        check("t3_b_rdy", b_ready, 0);
        check("t3_stall0", stall_cnt, 0);
        for (int k = 2; k < 8; k++) begin
            tick();
            check("t3_rw", reg_write, 1);
            check("t3_reg", write_reg, (k % 2 == 0) ? 3 : 30);
            check("t3_data", write_data,
                  (k % 2 == 0) ? 32'hAAAA_0000 : 32'hFFFF_0000);
            check("t3_stall", stall_cnt, k - 1);
        end

        // Saturation of the stall counter
        repeat (70000) @(posedge clk);
        #1;
        check("t5_sat", stall_cnt, 16'hFFFF);
        tick();
        check("t5_nowrap", stall_cnt, 16'hFFFF);
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) tick();
        check("t5_drained", busy, 0);

        // Write to register 0 is swallowed
        a_valid = 1'b1; a_reg = 5'd0; a_data = 32'hDEAD_BEEF;
        check("t4_ready", a_ready, 1);
        tick();
        check("t4_busy", busy, 0);
        check("t4_rw0", reg_write, 0);
        a_valid = 1'b0;
        tick();
        check("t4_rw1", reg_write, 0);
        check("t4_rf0", rf[0], 0);

`ifdef REGWR_FWD_EN
        // Forwarding priority: slot over output stage
        do_reset();
        b_valid = 1'b1; b_reg = 5'd5; b_data = 32'h44;
        tick();
        b_data = 32'h55;
        tick();
        b_valid = 1'b0;
        fwd_reg1 = 5'd5; fwd_reg2 = 5'd0;
        #1;
        check("t6_out_reg", write_reg, 5);
        check("t6_out_data", write_data, 32'h44);
        check("t6_hit1", fwd_hit1, 1);
        check("t6_data1", fwd_data1, 32'h55);
        check("t6_hit2", fwd_hit2, 0);
        check("t6_data2", fwd_data2, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the register file's single write port (write_reg / write_data / reg_write) between two writeback requesters.
  - Port A: ALU writeback.
  - Port B: memory-load writeback.
- Each requester uses a valid/ready handshake and gets a one-entry holding slot.
- Round-robin arbitration between slots; granted entry is registered onto the register-file write port.
- Sits between the writeback stage and register_file; register_file captures on the following posedge clk.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  requester A has a write.
- a_ready  output  1  requester A write accepted this cycle.
- a_reg  input  ADDR_W  requester A destination register.
- a_data  input  DATA_W  requester A write data.
- b_valid  input  1  requester B has a write.
- b_ready  output  1  requester B write accepted this cycle.
- b_reg  input  ADDR_W  requester B destination register.
- b_data  input  DATA_W  requester B write data.
- write_reg  output  ADDR_W  to register_file write_reg.
- write_data  output  DATA_W  to register_file write_data.
- reg_write  output  1  to register_file reg_write.
- busy  output  1  either holding slot occupied.
- stall_cnt  output  CNT_W  saturating count of stalled requester-cycles.

Behaviour:
- Reset:
  - Clock is clk; reset is rst_n, asynchronous, active-low.
  - Reset clears hold_a_v, hold_b_v, write_reg, write_data, reg_write, stall_cnt and busy to 0.
  - Reset sets last_grant=B, so A wins the first tie.
- Holding slots: one per requester, holding {v, reg, data}.
- Grant (combinational from slots and last_grant only, never from inputs):
  - Only one slot valid: that slot is granted.
  - Both slots valid: the one not equal to last_grant is granted.
  - Neither valid: no grant.
- Ready:
  - a_ready = !hold_a_v || grant_a; b_ready likewise.
  - A lone requester sustains one write per cycle.
- Accept (valid && ready at posedge):
  - Slot loads reg/data, v=1.
  - If reg==0, the write is accepted but discarded: v stays 0 and reg_write is never issued (register 0 is never written).
- Issue (at posedge with a grant):
  - write_reg/write_data take the granted slot's contents; reg_write=1; last_grant is updated.
  - The granted slot clears unless refilled by a same-edge accept.
- No grant: reg_write=0 next cycle; write_reg/write_data hold their last values.
- Latency: accept at edge N; earliest reg_write=1 after edge N+1; register_file stores at edge N+2.
- Ordering:
  - In order per requester.
  - Across requesters, order is arbitration order. The same destination from A and B back to back lands in grant order.
- stall_cnt: +1 per requester per cycle with valid && !ready (+2 when both stall); saturates at all-ones.
- busy = hold_a_v || hold_b_v.
- Reset mid-operation: pending slot contents are lost; any reg_write pulse in flight is cleared immediately.

Optional Feature:
- Macro: REGWR_FWD_EN.
- Defined:
  - Adds ports fwd_reg1, fwd_reg2 (input ADDR_W), fwd_hit1, fwd_hit2 (output 1) and fwd_data1, fwd_data2 (output DATA_W).
  - fwd_hitN=1 when fwd_regN!=0 and it matches a valid slot or the output stage (reg_write=1).
  - Priority for data:
    1. Non-granted valid slot.
    2. Granted slot.
    3. Output stage.
  - Purely combinational.
  - Outputs are 0 on miss.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- constant_values.h gains:
  - REG_ADDR_ZERO (5'b00000).
  - GRANT_A / GRANT_B encodings.
  - Reuse of the existing WORD_ZERO.
- Sub-module reg_write_slot, instantiated twice: one-entry holding register with accept/clear and reg-0 discard.

Test Plan:
1. Reset with rst_n=0 mid-cycle while a slot holds a write -> all outputs 0 immediately; after release, A wins the first tie.
2. A alone sends reg 1 = 0x0000FFFF, reg 2 = 0x12345678 on consecutive cycles -> a_ready stays 1; reg_write=1 for two consecutive cycles with write_reg 1 then 2; register_file reads back both values.
3. A (reg 3, 0xAAAA0000) and B (reg 30, 0xFFFF0000) both held every cycle -> grants alternate A,B,A,B; stall_cnt increments by 1 per cycle.
4. A writes reg 0 = 0xDEADBEEF -> a_ready=1, reg_write stays 0, busy stays 0, register 0 unchanged.
5. Both requesters held continuously for 70000 cycles -> stall_cnt saturates at 0xFFFF and does not wrap.
6. With REGWR_FWD_EN: B slot holds reg 5 = 0x55, output stage has reg 5 = 0x44, fwd_reg1=5 -> fwd_hit1=1, fwd_data1=0x55; fwd_reg2=0 -> fwd_hit2=0.
